hamm_secded_stream_dec: RTL and testbench

HAMM_SECDED_STREAM_DEC -- requirements
Module: hamm_secded_stream_dec

---
 rtl/hamm_secded_stream_dec.sv | 156 +++++++++++++++
 tb/tb_hamm_secded_stream_dec.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamm_secded_stream_dec.sv
// Hamming SECDED stream decoder with optional error counters (define HAMM_SECDED_ERR_CNT_EN to build them).
// Latency: 2 cycles from input transfer to out_valid; one word per cycle throughput.
// Backpressure: out_ready low holds S2 stable; in_ready falls only when both stages are full and stalled.
module hamm_secded_stream_dec #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    // smallest P with 2^P >= DATA_W+P+1, over the supported DATA_W range
    localparam int PAR_W  = (DATA_W + 4 <= 8)  ? 3 :
                            (DATA_W + 5 <= 16) ? 4 :
                            (DATA_W + 6 <= 32) ? 5 :
                            (DATA_W + 7 <= 64) ? 6 : 7,
    localparam int N      = DATA_W + PAR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      code_in,
    input  logic              par_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PAR_W-1:0]  syndrome,
    output logic              sbe,
    output logic              dbe,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt
);

    logic              s1_vld;
    logic [N-1:0]      s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_pc;
    logic              s2_vld;
    logic              s2_load;
    logic [PAR_W-1:0]  syn_c;
    logic              pc_c;
    logic [N-1:0]      corr_c;
    logic [DATA_W-1:0] data_c;
    logic              sbe_c;
    logic              dbe_c;

    assign s2_load   = ~s2_vld | out_ready;
    assign in_ready  = ~s1_vld | s2_load;
    assign out_valid = s2_vld;

    always_comb begin : syn_calc
        syn_c = '0;
        for (int p = 1; p <= N; p++) begin
            for (int i = 0; i < PAR_W; i++) begin
                if (((p >> i) & 1) == 1) begin
                    syn_c[i] = syn_c[i] ^ code_in[p-1];
                end
            end
        end
        pc_c = ^{code_in, par_in};
    end

    always_comb begin : correct
        sbe_c  = 1'b0;
        dbe_c  = 1'b0;
        corr_c = s1_code;
        data_c = '0;
        if (int'(s1_syn) > N) begin
            dbe_c = 1'b1;
        end else if (s1_syn == '0) begin
            // zero syndrome with odd overall parity: only par_in was hit
            sbe_c = s1_pc;
        end else if (s1_pc) begin
            sbe_c = 1'b1;
            for (int p = 1; p <= N; p++) begin
                if (int'(s1_syn) == p) begin
                    corr_c[p-1] = ~corr_c[p-1];
                end
            end
        end else begin
            dbe_c = 1'b1;
        end
        // data bit index = position minus the powers of two at or below it
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                data_c[p - 1 - $clog2(p + 1)] = corr_c[p-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_code <= '0;
            s1_syn  <= '0;
            s1_pc   <= 1'b0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_code <= code_in;
                s1_syn  <= syn_c;
                s1_pc   <= pc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            data_out <= '0;
            syndrome <= '0;
            sbe      <= 1'b0;
            dbe      <= 1'b0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                data_out <= data_c;
                syndrome <= s1_syn;
                sbe      <= sbe_c;
                dbe      <= dbe_c;
            end else begin
                data_out <= '0;
                syndrome <= '0;
                sbe      <= 1'b0;
                dbe      <= 1'b0;
            end
        end
    end

`ifdef HAMM_SECDED_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic out_xfer;
    assign out_xfer = s2_vld & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else if (cnt_clr) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else if (out_xfer) begin
            if (sbe && (sbe_cnt != CNT_MAX)) begin
                sbe_cnt <= sbe_cnt + CNT_W'(1);
            end
            if (dbe && (dbe_cnt != CNT_MAX)) begin
                dbe_cnt <= dbe_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sbe_cnt        = '0;
    assign dbe_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamm_secded_stream_dec.sv
// Randomized scoreboard bench for hamm_secded_stream_dec: driver pushes model results, monitor pops on output transfers.
module tb_hamm_secded_stream_dec;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int PAR_W  = 4;
    localparam int N      = 12;
    localparam int CMAX   = 15;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [PAR_W-1:0]  syn;
        logic              sbe;
        logic              dbe;
        int                acc_cyc;
        logic              chk_lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      code_in;
    logic              par_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic [PAR_W-1:0]  syndrome;
    logic              sbe;
    logic              dbe;
    logic              cnt_clr;
    logic [CNT_W-1:0]  sbe_cnt;
    logic [CNT_W-1:0]  dbe_cnt;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    exp_t sb[$];

    hamm_secded_stream_dec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .par_in(par_in),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .syndrome(syndrome),
        .sbe(sbe), .dbe(dbe), .cnt_clr(cnt_clr), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Build a clean codeword: scatter data over non-power-of-two positions, then
    // pick parity bits so the XOR of all set positions is zero.
    function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
        logic [N-1:0] c;
        int j;
        int s;
        c = '0;
        j = 0;
        for (int q = 1; q <= N; q++) begin
            if ((q & (q - 1)) != 0) begin
                c[q-1] = d[j];
                j++;
            end
        end
        s = 0;
        for (int q = 1; q <= N; q++) if (c[q-1]) s = s ^ q;
        for (int i = 0; i < PAR_W; i++) c[(1 << i) - 1] = s[i];
        return c;
    endfunction

    function automatic exp_t model(input logic [N-1:0] c, input logic p);
        exp_t e;
        int s;
        int j;
        logic [N-1:0] w;
        logic odd;
        s = 0;
        for (int q = 1; q <= N; q++) if (c[q-1]) s = s ^ q;
        odd = (($countones(c) + int'(p)) % 2) == 1;
        e.sbe = 1'b0;
        e.dbe = 1'b0;
        w = c;
        if (s > N) e.dbe = 1'b1;
        else if (s == 0) e.sbe = odd;
        else if (odd) begin
            w[s-1] = ~w[s-1];
            e.sbe = 1'b1;
        end else e.dbe = 1'b1;
        e.data = '0;
        j = 0;
        for (int q = 1; q <= N; q++) begin
            if ((q & (q - 1)) != 0) begin
                e.data[j] = w[q-1];
                j++;
            end
        end
        e.syn = s[PAR_W-1:0];
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [N-1:0] c, input logic p,
                         input logic clr, output logic acc);
        exp_t e;
        logic exp_rdy;
        @(negedge clk);
        in_valid = v;
        code_in  = c;
        par_in   = p;
        cnt_clr  = clr;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        exp_rdy = !rst_n || !((sb.size() == 2) && !out_ready);
        chk("in_ready", in_ready, exp_rdy);
        acc = v && in_ready && rst_n;
        if (acc) begin
            e = model(c, p);
            e.acc_cyc = cyc + 1;
            e.chk_lat = (rdy_mode == 0);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, a);
    endtask

    task automatic send(input logic [N-1:0] c, input logic p);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 50 && !a; t++) drive(1'b1, c, p, 1'b0, a);
        if (!a) chk("send_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops and compares on every output transfer, checks stall stability and counters.
    initial begin
        exp_t e;
        logic stall_prev;
        logic [DATA_W-1:0] pd;
        logic [PAR_W-1:0] ps;
        logic psb, pdb, xfer, e_sbe, e_dbe;
        int m_sbe, m_dbe;
        stall_prev = 1'b0;
        pd = '0; ps = '0; psb = 1'b0; pdb = 1'b0;
        m_sbe = 0; m_dbe = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                sb.delete();
                m_sbe = 0;
                m_dbe = 0;
                stall_prev = 1'b0;
                continue;
            end
`ifdef HAMM_SECDED_ERR_CNT_EN
            chk("sbe_cnt", sbe_cnt, m_sbe);
            chk("dbe_cnt", dbe_cnt, m_dbe);
`else
            chk("sbe_cnt_tied", sbe_cnt, 0);
            chk("dbe_cnt_tied", dbe_cnt, 0);
`endif
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", data_out, pd);
                chk("hold_flags", {syndrome, sbe, dbe}, {ps, psb, pdb});
            end
            if (!out_valid) chk("idle_flags_zero", {syndrome, sbe, dbe}, 0);
            chk("sbe_dbe_exclusive", sbe & dbe, 0);
            xfer = out_valid && out_ready;
            e_sbe = 1'b0;
            e_dbe = 1'b0;
            if (xfer) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    e_sbe = e.sbe;
                    e_dbe = e.dbe;
                    chk("data_out", data_out, e.data);
                    chk("syndrome", syndrome, e.syn);
                    chk("sbe", sbe, e.sbe);
                    chk("dbe", dbe, e.dbe);
                    if (e.chk_lat) chk("latency", cyc + 1 - e.acc_cyc, 2);
                end
            end
            if (cnt_clr) begin
                m_sbe = 0;
                m_dbe = 0;
            end else if (xfer) begin
                if (e_sbe && m_sbe < CMAX) m_sbe++;
                if (e_dbe && m_dbe < CMAX) m_dbe++;
            end
            stall_prev = out_valid && !out_ready;
            pd = data_out; ps = syndrome; psb = sbe; pdb = dbe;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (vectors %0d)", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] c;
        logic [N-1:0] one;
        logic a;
        logic p;
        int k1, k2;
        one = 1;
        in_valid = 1'b0; code_in = '0; par_in = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {data_out, syndrome, sbe, dbe}, 0);
        chk("rst_counters", {sbe_cnt, dbe_cnt}, 0);
        idle(2);
        #2 rst_n = 1'b1;
        #1 chk("in_ready_after_release", in_ready, 1);

        // Directed words, out_ready held high
        rdy_mode = 0;
        send(12'hA27, 1'b0);
        send(12'hA07, 1'b0);
        send(12'hA03, 1'b0);
        send(12'hA27, 1'b1);
        send(12'hA27 ^ 12'h801, 1'b0);
        send(12'hA27 ^ 12'h801, 1'b1);
        send(12'hA27 ^ 12'h803, 1'b0);
        drain();

        // Eight-word stream with out_ready toggling every cycle
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            c = encode(8'($urandom));
            if (i % 3 == 1) c = c ^ (one << $urandom_range(0, N - 1));
            send(c, ^c);
        end
        drain();

        // Random traffic with random backpressure and error injection
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            c = encode(8'($urandom));
            p = ^c;
            case ($urandom_range(0, 4))
                0: ;
                1: c = c ^ (one << $urandom_range(0, N - 1));
                2: p = ~p;
                3: begin
                    k1 = $urandom_range(0, N - 1);
                    k2 = (k1 + 1 + $urandom_range(0, N - 2)) % N;
                    c = c ^ (one << k1) ^ (one << k2);
                end
                default: begin
                    c = 12'($urandom);
                    p = 1'($urandom);
                end
            endcase
            send(c, p);
            if ($urandom_range(0, 3) == 0) drive(1'b0, '0, 1'b0, 1'($urandom_range(0, 15) == 0), a);
        end
        drain();

        // Saturation, then clear colliding with an sbe transfer
        rdy_mode = 0;
        for (int i = 0; i < CMAX + 3; i++) send(12'hA07, 1'b0);
        send(12'hA03, 1'b0);
        drain();
        send(12'hA07, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, a);
        drive(1'b0, '0, 1'b0, 1'b1, a);
        idle(2);
        send(12'hA07, 1'b0);
        drain();

        // Reset with two words in flight
        send(12'hA07, 1'b0);
        send(12'hA03, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, a);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {data_out, syndrome, sbe, dbe}, 0);
        chk("midrst_counters", {sbe_cnt, dbe_cnt}, 0);
        chk("midrst_in_ready", in_ready, 1);
        idle(2);
        #2 rst_n = 1'b1;
        #1 chk("in_ready_after_midrst", in_ready, 1);
        send(12'hA27, 1'b0);
        send(12'hA07, 1'b0);
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
